// File: rtl/lstm_ctrl_pkg.sv
// Shared types and pass-length helpers for the LSTM forward-pass sequencer.
package lstm_ctrl_pkg;

  typedef enum logic [1:0] {
    TOP_IDLE,
    TOP_L1,
    TOP_L2,
    TOP_DONE
  } top_state_e;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_ACC,
    SEQ_DRAIN,
    SEQ_WR,
    SEQ_CLR
  } seq_state_e;

  function automatic int unsigned pass_len(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned cell_cycles(input int unsigned n);
    return n + 3;
  endfunction

endpackage

// File: rtl/lstm_layer_seq.sv
// One layer: ACC (N taps) -> DRAIN -> WR -> CLR per cell, for every cell at timestep t_i.
// state | meaning: IDLE wait for go | ACC dot-product pass | DRAIN let the pipe settle | WR h/c write-back | CLR acc clear
module lstm_layer_seq
  import lstm_ctrl_pkg::*;
#(
  parameter int unsigned IN   = 53,
  parameter int unsigned CELL = 53,
  parameter int unsigned ADDR = 12,
  parameter int unsigned TW   = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            go_i,
  input  logic [TW-1:0]   t_i,
  output logic            last_cell_o,
  output logic            clr_o,
  output logic            acc_x_o,
  output logic            acc_h_o,
  output logic [ADDR-1:0] rd_addr_x_o,
  output logic [ADDR-1:0] rd_addr_w_o,
  output logic [ADDR-1:0] rd_addr_u_o,
  output logic [ADDR-1:0] rd_addr_h_o,
  output logic [ADDR-1:0] rd_addr_b_o,
  output logic            wr_o,
  output logic [ADDR-1:0] wr_addr_o
);

  localparam int unsigned N  = pass_len(IN, CELL);
  // k must be able to represent N itself so the k < IN / k < CELL compares never wrap
  localparam int unsigned KW = $clog2(N + 1);
  localparam int unsigned JW = (CELL > 1) ? $clog2(CELL) : 1;
  localparam logic [KW-1:0]   K_LAST = KW'(N - 1);
  localparam logic [KW-1:0]   K_IN   = KW'(IN);
  localparam logic [KW-1:0]   K_CELL = KW'(CELL);
  localparam logic [JW-1:0]   J_LAST = JW'(CELL - 1);
  localparam logic [ADDR-1:0] IN_A   = ADDR'(IN);
  localparam logic [ADDR-1:0] CELL_A = ADDR'(CELL);

  seq_state_e state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [JW-1:0] j_q, j_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEQ_IDLE;
      k_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      j_q     <= j_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    j_d     = j_q;
    case (state_q)
      SEQ_IDLE: if (go_i) begin
        state_d = SEQ_ACC;
        k_d     = '0;
        j_d     = '0;
      end
      SEQ_ACC: begin
        if (k_q == K_LAST) state_d = SEQ_DRAIN;
        else               k_d     = k_q + KW'(1);
      end
      SEQ_DRAIN: state_d = SEQ_WR;
      SEQ_WR:    state_d = SEQ_CLR;
      SEQ_CLR: begin
        k_d = '0;
        if (j_q == J_LAST) begin
          state_d = SEQ_IDLE;
          j_d     = '0;
        end else begin
          state_d = SEQ_ACC;
          j_d     = j_q + JW'(1);
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  logic            in_acc, addr_live, x_live, h_live, t_nz;
  logic [ADDR-1:0] t_a, k_a, j_a;

  assign t_a = ADDR'(t_i);
  assign k_a = ADDR'(k_q);
  assign j_a = ADDR'(j_q);
  assign t_nz = (t_i != '0);

  // DRAIN keeps k at its last value, so the read addresses hold their final-tap values
  assign in_acc    = (state_q == SEQ_ACC);
  assign addr_live = in_acc || (state_q == SEQ_DRAIN);
  assign x_live    = addr_live && (k_q < K_IN);
  assign h_live    = addr_live && (k_q < K_CELL);

  assign acc_x_o     = in_acc && (k_q < K_IN);
  assign acc_h_o     = in_acc && (k_q < K_CELL) && t_nz;
  assign rd_addr_x_o = x_live ? (t_a * IN_A + k_a) : '0;
  assign rd_addr_w_o = x_live ? (j_a * IN_A + k_a) : '0;
  assign rd_addr_u_o = h_live ? (j_a * CELL_A + k_a) : '0;
  assign rd_addr_h_o = (h_live && t_nz) ? ((t_a - ADDR'(1)) * CELL_A + k_a) : '0;
  assign rd_addr_b_o = addr_live ? j_a : '0;
  assign wr_o        = (state_q == SEQ_WR);
  assign wr_addr_o   = wr_o ? (t_a * CELL_A + j_a) : '0;
  assign clr_o       = (state_q == SEQ_CLR);
  assign last_cell_o = clr_o && (j_q == J_LAST);

endmodule

// File: rtl/lstm_fwd_ctrl.sv
// Two-layer LSTM forward-pass sequencer: owns IDLE/DONE, the timestep counter and the layer hand-off.
// state | meaning: IDLE wait for start | L1 layer-1 cells | L2 layer-2 cells | DONE one-cycle completion
module lstm_fwd_ctrl
  import lstm_ctrl_pkg::*;
#(
  parameter int unsigned TIMESTEP    = 7,
  parameter int unsigned LAYR1_INPUT = 53,
  parameter int unsigned LAYR1_CELL  = 53,
  parameter int unsigned LAYR2_CELL  = 8,
  parameter int unsigned ADDR        = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            acc_rst_1,
  output logic            acc_rst_2,
  output logic            acc_x_1,
  output logic            acc_h_1,
  output logic            acc_x_2,
  output logic            acc_h_2,
  output logic [ADDR-1:0] addr_x1,
  output logic [ADDR-1:0] rd_addr_w_1,
  output logic [ADDR-1:0] rd_addr_u_1,
  output logic [ADDR-1:0] rd_addr_b_1,
  output logic [ADDR-1:0] rd_addr_h1,
  output logic [ADDR-1:0] rd_addr_x2,
  output logic [ADDR-1:0] rd_addr_w_2,
  output logic [ADDR-1:0] rd_addr_u_2,
  output logic [ADDR-1:0] rd_addr_b_2,
  output logic [ADDR-1:0] rd_addr_h2,
  output logic            wr_h1,
  output logic            wr_c1,
  output logic            wr_h2,
  output logic            wr_c2,
  output logic [ADDR-1:0] wr_addr_h1,
  output logic [ADDR-1:0] wr_addr_c1,
  output logic [ADDR-1:0] wr_addr_h2,
  output logic [ADDR-1:0] wr_addr_c2
);

  localparam int unsigned TW = (TIMESTEP > 1) ? $clog2(TIMESTEP) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMESTEP - 1);

  if ((TIMESTEP * LAYR1_CELL > (1 << ADDR)) || (TIMESTEP * LAYR1_INPUT > (1 << ADDR))) begin : g_addr_range
    $error("lstm_fwd_ctrl: store sizes exceed the ADDR address space");
  end

  top_state_e state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic go1, go2, last1, last2, clr1, clr2, wr1, wr2;
  logic [ADDR-1:0] wa1, wa2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TOP_IDLE;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    go1     = 1'b0;
    go2     = 1'b0;
    case (state_q)
      TOP_IDLE: if (start) begin
        state_d = TOP_L1;
        t_d     = '0;
        go1     = 1'b1;
      end
      TOP_L1: if (last1) begin
        state_d = TOP_L2;
        go2     = 1'b1;
      end
      TOP_L2: if (last2) begin
        if (t_q == T_LAST) begin
          state_d = TOP_DONE;
        end else begin
          state_d = TOP_L1;
          t_d     = t_q + TW'(1);
          go1     = 1'b1;
        end
      end
      TOP_DONE: begin
        state_d = TOP_IDLE;
        if (start) begin
          state_d = TOP_L1;
          t_d     = '0;
          go1     = 1'b1;
        end
      end
      default: state_d = TOP_IDLE;
    endcase
  end

  lstm_layer_seq #(.IN(LAYR1_INPUT), .CELL(LAYR1_CELL), .ADDR(ADDR), .TW(TW)) u_l1 (
    .clk         (clk),
    .rst         (rst),
    .go_i        (go1),
    .t_i         (t_q),
    .last_cell_o (last1),
    .clr_o       (clr1),
    .acc_x_o     (acc_x_1),
    .acc_h_o     (acc_h_1),
    .rd_addr_x_o (addr_x1),
    .rd_addr_w_o (rd_addr_w_1),
    .rd_addr_u_o (rd_addr_u_1),
    .rd_addr_h_o (rd_addr_h1),
    .rd_addr_b_o (rd_addr_b_1),
    .wr_o        (wr1),
    .wr_addr_o   (wa1)
  );

  lstm_layer_seq #(.IN(LAYR1_CELL), .CELL(LAYR2_CELL), .ADDR(ADDR), .TW(TW)) u_l2 (
    .clk         (clk),
    .rst         (rst),
    .go_i        (go2),
    .t_i         (t_q),
    .last_cell_o (last2),
    .clr_o       (clr2),
    .acc_x_o     (acc_x_2),
    .acc_h_o     (acc_h_2),
    .rd_addr_x_o (rd_addr_x2),
    .rd_addr_w_o (rd_addr_w_2),
    .rd_addr_u_o (rd_addr_u_2),
    .rd_addr_h_o (rd_addr_h2),
    .rd_addr_b_o (rd_addr_b_2),
    .wr_o        (wr2),
    .wr_addr_o   (wa2)
  );

  assign busy       = (state_q != TOP_IDLE);
  assign done       = (state_q == TOP_DONE);
  assign acc_rst_1  = (state_q != TOP_L1) || clr1;
  assign acc_rst_2  = (state_q != TOP_L2) || clr2;
  assign wr_h1      = wr1;
  assign wr_c1      = wr1;
  assign wr_h2      = wr2;
  assign wr_c2      = wr2;
  assign wr_addr_h1 = wa1;
  assign wr_addr_c1 = wa1;
  assign wr_addr_h2 = wa2;
  assign wr_addr_c2 = wa2;

endmodule
